// File: rtl/crc_master_pkg.sv
// rtl/crc_master_pkg.sv - register map, bus encodings and state types for the CRC stream master
package crc_master_pkg;

    localparam logic [5:0] REG_EN   = 6'h00;
    localparam logic [5:0] REG_CFG  = 6'h04;
    localparam logic [5:0] REG_DIN  = 6'h08;
    localparam logic [5:0] REG_RES  = 6'h0C;
    localparam logic [5:0] REG_POLY = 6'h10;

    localparam logic [1:0] SZ_NONE = 2'b11;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] RD_NONE = 2'b11;
    localparam logic [1:0] RD_WORD = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_W_POLY, S_W_CFG, S_W_EN1, S_FEED,
        S_DRAIN, S_W_EN0, S_WAIT, S_R_RES, S_RESULT
    } master_state_t;

    typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ, B_GAP} bus_state_t;

endpackage

// File: rtl/crc_stream_master_if.sv
// rtl/crc_stream_master_if.sv - register port between the stream master and the CRC32 peripheral
interface crc_stream_master_if;
    logic [5:0]  address;
    logic [31:0] wdata;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] rdata;
    logic        data_ready;

    modport master (
        output address, wdata, data_write_n, data_read_n,
        input  rdata, data_ready
    );

    modport slave (
        input  address, wdata, data_write_n, data_read_n,
        output rdata, data_ready
    );
endinterface

// File: rtl/bus_access_seq.sv
// rtl/bus_access_seq.sv - executes one register write or read, then forces one idle gap cycle
module bus_access_seq
    import crc_master_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_read,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic        idle,
    output logic        done,
    output logic        timeout,
    crc_stream_master_if.master bus
);
    localparam int WW = $clog2(TIMEOUT + 2);

    bus_state_t  state, state_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic [5:0]  addr_n;
    logic [31:0] wdata_n;
    logic [1:0]  wr_n, rd_n;

    assign idle    = (state == B_IDLE);
    assign done    = (state == B_WRITE) || (state == B_READ && bus.data_ready);
    assign timeout = (state == B_READ) && !bus.data_ready && (wait_cnt > WW'(TIMEOUT));

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        addr_n     = bus.address;
        wdata_n    = bus.wdata;
        wr_n       = bus.data_write_n;
        rd_n       = bus.data_read_n;
        case (state)
            B_IDLE: if (req) begin
                addr_n     = req_addr;
                wait_cnt_n = '0;
                if (req_read) begin
                    rd_n    = RD_WORD;
                    state_n = B_READ;
                end else begin
                    wdata_n = req_wdata;
                    wr_n    = req_size;
                    state_n = B_WRITE;
                end
            end
            B_WRITE: begin
                addr_n  = '0;
                wdata_n = '0;
                wr_n    = SZ_NONE;
                state_n = B_GAP;
            end
            B_READ: begin
                if (bus.data_ready || timeout) begin
                    addr_n  = '0;
                    rd_n    = RD_NONE;
                    state_n = B_GAP;
                end else if (wait_cnt != '1) begin
                    wait_cnt_n = wait_cnt + WW'(1);
                end
            end
            B_GAP:   state_n = B_IDLE;
            default: state_n = B_IDLE;
        endcase
    end

    // Bus outputs are registered so an asynchronous reset idles the port immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= B_IDLE;
            wait_cnt         <= '0;
            bus.address      <= '0;
            bus.wdata        <= '0;
            bus.data_write_n <= SZ_NONE;
            bus.data_read_n  <= RD_NONE;
        end else begin
            state            <= state_n;
            wait_cnt         <= wait_cnt_n;
            bus.address      <= addr_n;
            bus.wdata        <= wdata_n;
            bus.data_write_n <= wr_n;
            bus.data_read_n  <= rd_n;
        end
    end
endmodule

// File: rtl/crc_stream_master.sv
// rtl/crc_stream_master.sv - streams bytes into the CRC32 peripheral and returns the frame result
module crc_stream_master
    import crc_master_pkg::*;
#(
    parameter int BURST   = 4,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg,
    input  logic [31:0] poly,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        res_valid,
    output logic [31:0] res_crc,
    input  logic        res_ready,
    output logic        busy,
    output logic        err,
    crc_stream_master_if.master bus
);
    localparam int CW = $clog2(BURST + 1);
    localparam int SW = $clog2(SETTLE + 1);

    master_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [SW-1:0] settle_cnt;
    logic          last_seen, abort_pend, aborting;
    logic [7:0]    cfg_q;
    logic [31:0]   poly_q;

    logic        req, req_read, seq_idle, seq_done, seq_timeout;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;

    bus_access_seq #(.TIMEOUT(TIMEOUT)) u_seq (
        .clk(clk), .rst(rst), .req(req), .req_read(req_read), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .idle(seq_idle), .done(seq_done),
        .timeout(seq_timeout), .bus(bus)
    );

    assign aborting  = abort || abort_pend;
    assign res_valid = (state == S_RESULT);
    assign busy      = (state != S_IDLE);
    assign err       = seq_timeout;

    // Each state issues its access only while the sequencer is idle, and advances on done.
    always_comb begin
        state_n   = state;
        req       = 1'b0;
        req_read  = 1'b0;
        req_addr  = REG_EN;
        req_wdata = '0;
        req_size  = SZ_BYTE;
        s_ready   = 1'b0;
        case (state)
            S_IDLE: if (start && !abort) state_n = S_W_POLY;
            S_W_POLY, S_W_CFG, S_W_EN1: begin
                if (seq_idle) begin
                    if (aborting) state_n = S_W_EN0;
                    else begin
                        req = 1'b1;
                        if (state == S_W_POLY) begin
                            req_addr = REG_POLY; req_wdata = poly_q; req_size = SZ_WORD;
                        end else if (state == S_W_CFG) begin
                            req_addr = REG_CFG; req_wdata = {24'h0, cfg_q};
                        end else begin
                            req_addr = REG_EN; req_wdata = 32'h1;
                        end
                    end
                end else if (seq_done) begin
                    state_n = (state == S_W_POLY) ? S_W_CFG :
                              (state == S_W_CFG)  ? S_W_EN1 : S_FEED;
                end
            end
            S_FEED: if (seq_idle) begin
                if (aborting) state_n = S_W_EN0;
                else if (cnt == CW'(BURST) || last_seen) state_n = S_DRAIN;
                else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        req = 1'b1; req_addr = REG_DIN; req_wdata = {24'h0, s_data};
                    end
                end
            end
            S_DRAIN, S_R_RES: begin
                if (seq_idle) begin
                    if (aborting) state_n = S_W_EN0;
                    else begin
                        req = 1'b1; req_read = 1'b1; req_addr = REG_RES; req_size = SZ_NONE;
                    end
                end else if (seq_timeout) begin
                    state_n = S_IDLE;
                end else if (seq_done) begin
                    if (aborting || (state == S_DRAIN && last_seen)) state_n = S_W_EN0;
                    else state_n = (state == S_DRAIN) ? S_FEED : S_RESULT;
                end
            end
            S_W_EN0: begin
                if (seq_idle) begin
                    req = 1'b1; req_addr = REG_EN; req_wdata = 32'h0;
                end else if (seq_done) begin
                    state_n = aborting ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (aborting) state_n = S_W_EN0;
                else if (settle_cnt == SW'(SETTLE - 1)) state_n = S_R_RES;
            end
            S_RESULT: if (abort || res_ready) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            settle_cnt <= '0;
            last_seen  <= 1'b0;
            abort_pend <= 1'b0;
            cfg_q      <= '0;
            poly_q     <= '0;
            res_crc    <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && state_n == S_W_POLY) begin
                cfg_q     <= cfg;
                poly_q    <= poly;
                cnt       <= '0;
                last_seen <= 1'b0;
            end
            if (s_ready && s_valid) begin
                cnt       <= cnt + CW'(1);
                last_seen <= last_seen | s_last;
            end
            if (state == S_DRAIN && seq_done) cnt <= '0;
            if (state_n == S_IDLE) abort_pend <= 1'b0;
            else if (abort && state != S_IDLE) abort_pend <= 1'b1;
            if (state != S_WAIT) settle_cnt <= '0;
            else if (settle_cnt != '1) settle_cnt <= settle_cnt + SW'(1);
            if (state == S_R_RES && seq_done) res_crc <= bus.rdata;
        end
    end
endmodule

// File: tb/tb_crc_stream_master.sv
// tb/tb_crc_stream_master.sv - self-checking bench with a CRC32 peripheral model and result scoreboard
module tb_crc_stream_master;
    typedef struct {
        bit          is_rd;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [1:0]  sz;
    } acc_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0, abort = 1'b0, s_valid = 1'b0, s_last = 1'b0, res_ready = 1'b0;
    logic [7:0]  cfg = '0, s_data = '0;
    logic [31:0] poly = '0;
    logic s_ready, res_valid, busy, err;
    logic [31:0] res_crc;

    crc_stream_master_if bus();

    crc_stream_master #(.BURST(4), .SETTLE(4), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg(cfg), .poly(poly), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .res_valid(res_valid), .res_crc(res_crc), .res_ready(res_ready),
        .busy(busy), .err(err), .bus(bus)
    );

    int total = 0, bad = 0;
    int proto_bad = 0, rd_cycles = 0, rd_wait = 0;
    bit gap_due = 1'b0, stall_res = 1'b0;
    acc_t log_q[$], exp_log[$];
    logic [7:0]  frame_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_crc = '0, m_res = '0, m_poly = '0;
    logic [7:0]  m_cfg = '0;
    logic        m_en = 1'b0;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b,
                                             input logic refl, input logic [31:0] p);
        logic [31:0] r, rp;
        r = c;
        for (int i = 0; i < 32; i++) rp[i] = p[31-i];
        if (refl) begin
            r = r ^ {24'h0, b};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ rp) : (r >> 1);
        end else begin
            r = r ^ {b, 24'h0};
            for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ p) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_ref(input logic [7:0] c, input logic [31:0] p);
        logic [31:0] r;
        r = c[2] ? 32'hFFFF_FFFF : 32'h0;
        foreach (frame_q[i]) r = crc_byte(r, frame_q[i], c[0], p);
        return c[1] ? ~r : r;
    endfunction

    // Peripheral model plus bus-gap monitor.
    always @(posedge clk) begin
        if (rst) begin
            bus.data_ready <= 1'b0;
            bus.rdata      <= '0;
            rd_wait        <= 0;
            gap_due        <= 1'b0;
        end else begin
            if (gap_due && (bus.address !== 6'h0 || bus.wdata !== 32'h0 ||
                            bus.data_write_n !== 2'b11 || bus.data_read_n !== 2'b11))
                proto_bad <= proto_bad + 1;
            gap_due <= (bus.data_write_n != 2'b11) || (bus.data_read_n == 2'b10 && bus.data_ready);
            if (bus.data_write_n != 2'b11) begin
                log_q.push_back('{1'b0, bus.address, bus.wdata, bus.data_write_n});
                case (bus.address)
                    6'h10: m_poly <= bus.wdata;
                    6'h04: m_cfg  <= bus.wdata[7:0];
                    6'h00: if (bus.wdata[0]) begin
                        m_en <= 1'b1; m_crc <= m_cfg[2] ? 32'hFFFF_FFFF : 32'h0;
                    end else begin
                        m_en <= 1'b0; m_res <= m_cfg[1] ? ~m_crc : m_crc;
                    end
                    6'h08: if (m_en) m_crc <= crc_byte(m_crc, bus.wdata[7:0], m_cfg[0], m_poly);
                    default: ;
                endcase
            end
            if (bus.data_read_n == 2'b10) begin
                rd_cycles <= rd_cycles + 1;
                if (bus.data_ready) begin
                    log_q.push_back('{1'b1, bus.address, bus.rdata, 2'b10});
                    bus.data_ready <= 1'b0;
                    rd_wait        <= 0;
                end else if (rd_wait >= 2 && !stall_res) begin
                    bus.data_ready <= 1'b1;
                    bus.rdata      <= m_en ? 32'h0 : m_res;
                end else begin
                    rd_wait <= rd_wait + 1;
                end
            end else begin
                bus.data_ready <= 1'b0;
                rd_wait        <= 0;
            end
        end
    end

    task automatic load_str(input string s);
        frame_q.delete();
        for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
    endtask

    task automatic start_frame(input logic [7:0] c, input logic [31:0] p);
        @(negedge clk);
        cfg = c; poly = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, output bit ok);
        int n = 0;
        s_valid = 1'b1; s_data = b; s_last = l;
        while (s_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        ok = (s_ready === 1'b1);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(output bit ok);
        bit o;
        ok = 1'b1;
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], i == frame_q.size() - 1, o);
            if (!o) begin ok = 1'b0; break; end
        end
    endtask

    task automatic wait_result(output bit got);
        int n = 0;
        while (res_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        got = (res_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (bus.data_write_n !== 2'b11) begin bad++; $display("FAIL reset_write_n got=%b want=11", bus.data_write_n); end
        total++; if (bus.data_read_n !== 2'b11) begin bad++; $display("FAIL reset_read_n got=%b want=11", bus.data_read_n); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (res_valid !== 1'b0 || err !== 1'b0 || bus.address !== 6'h0) begin
            bad++; $display("FAIL reset_outputs got res_valid=%b err=%b addr=%h want 0", res_valid, err, bus.address);
        end
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0; @(negedge clk);
        total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL idle_res_ready got busy=%b want=0", busy); end
    endtask

    task automatic test_check_vector();
        bit ok, got;
        logic [31:0] exp;
        load_str("123456789");
        log_q.delete();
        exp_q.push_back(32'hCBF4_3926);
        start_frame(8'h07, 32'h04C1_1DB7);
        send_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL vec_feed got=stalled want=accepted"); end
        wait_result(got);
        exp = exp_q.pop_front();
        total++; if (!got || res_crc !== exp) begin bad++; $display("FAIL vec_crc got=%h valid=%b want=%h", res_crc, got, exp); end
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0; @(negedge clk);
        total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL vec_release got busy=%b res_valid=%b want 0", busy, res_valid); end
        exp_log.delete();
        exp_log.push_back('{1'b0, 6'h10, 32'h04C1_1DB7, 2'b10});
        exp_log.push_back('{1'b0, 6'h04, 32'h0000_0007, 2'b00});
        exp_log.push_back('{1'b0, 6'h00, 32'h0000_0001, 2'b00});
        for (int i = 0; i < 9; i++) begin
            exp_log.push_back('{1'b0, 6'h08, {24'h0, frame_q[i]}, 2'b00});
            if (i == 3 || i == 7 || i == 8) exp_log.push_back('{1'b1, 6'h0C, 32'h0, 2'b10});
        end
        exp_log.push_back('{1'b0, 6'h00, 32'h0, 2'b00});
        exp_log.push_back('{1'b1, 6'h0C, 32'h0, 2'b10});
        total++; if (log_q.size() != exp_log.size()) begin bad++; $display("FAIL vec_access_count got=%0d want=%0d", log_q.size(), exp_log.size()); end
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++) begin
            total++;
            if (log_q[i].is_rd !== exp_log[i].is_rd || log_q[i].addr !== exp_log[i].addr ||
                log_q[i].sz !== exp_log[i].sz || (!exp_log[i].is_rd && log_q[i].data !== exp_log[i].data)) begin
                bad++;
                $display("FAIL vec_access[%0d] got rd=%0d addr=%h data=%h sz=%b want rd=%0d addr=%h data=%h sz=%b",
                         i, log_q[i].is_rd, log_q[i].addr, log_q[i].data, log_q[i].sz,
                         exp_log[i].is_rd, exp_log[i].addr, exp_log[i].data, exp_log[i].sz);
            end
        end
        total++; if (proto_bad != 0) begin bad++; $display("FAIL vec_gap got=%0d violations want=0", proto_bad); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0, base;
        load_str("TMOT");
        log_q.delete();
        stall_res = 1'b1;
        start_frame(8'h07, 32'h04C1_1DB7);
        base = rd_cycles;
        for (int i = 0; i < 4; i++) send_byte(frame_q[i], 1'b0, ok);
        while (err !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err got=0 want=1"); end
        total++; if (rd_cycles - base != 1024) begin bad++; $display("FAIL tmo_wait got=%0d want=1024", rd_cycles - base); end
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_pulse got=%b want=0", err); end
        total++; if (bus.data_read_n !== 2'b11 || bus.address !== 6'h0) begin
            bad++; $display("FAIL tmo_bus got read_n=%b addr=%h want 11/00", bus.data_read_n, bus.address);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", busy); end
        stall_res = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok, got, saw_valid = 1'b0;
        int n = 0, din = 0, reads = 0;
        logic [31:0] exp;
        load_str("ABORTX");
        log_q.delete();
        start_frame(8'h07, 32'h04C1_1DB7);
        for (int i = 0; i < 3; i++) send_byte(frame_q[i], 1'b0, ok);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            if (res_valid === 1'b1) saw_valid = 1'b1;
            @(negedge clk); n++;
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (saw_valid) begin bad++; $display("FAIL abort_res_valid got=1 want=0"); end
        total++; if (log_q.size() == 0 || log_q[$].is_rd || log_q[$].addr !== 6'h00 || log_q[$].data !== 32'h0) begin
            bad++; $display("FAIL abort_en0 got last access missing or not EN=0 (size=%0d) want EN write 0", log_q.size());
        end
        foreach (log_q[i]) if (!log_q[i].is_rd && log_q[i].addr == 6'h08) din++;
        total++; if (din != 3) begin bad++; $display("FAIL abort_din got=%0d want=3", din); end

        load_str("ABCDEFGH");
        log_q.delete();
        exp_q.push_back(crc_ref(8'h07, 32'h04C1_1DB7));
        start_frame(8'h07, 32'h04C1_1DB7);
        send_frame(ok);
        wait_result(got);
        exp = exp_q.pop_front();
        total++; if (!got || res_crc !== exp) begin bad++; $display("FAIL post_abort_crc got=%h valid=%b want=%h", res_crc, got, exp); end
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0; @(negedge clk);
        foreach (log_q[i]) if (log_q[i].is_rd) reads++;
        total++; if (reads != 3) begin bad++; $display("FAIL burst_last_reads got=%0d want=3", reads); end
    endtask

    task automatic test_hold();
        bit ok, got;
        int hold_bad = 0, log_n;
        logic [31:0] exp, held;
        load_str("abc");
        log_q.delete();
        exp_q.push_back(crc_ref(8'h05, 32'h04C1_1DB7));
        start_frame(8'h05, 32'h04C1_1DB7);
        send_frame(ok);
        wait_result(got);
        exp = exp_q.pop_front();
        total++; if (!got || res_crc !== exp) begin bad++; $display("FAIL hold_crc got=%h valid=%b want=%h", res_crc, got, exp); end
        held = res_crc;
        log_n = log_q.size();
        for (int i = 0; i < 50; i++) begin
            start = (i == 10);
            cfg = 8'h00; poly = 32'h1EDC_6F41;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_crc !== held) hold_bad++;
        end
        start = 1'b0;
        total++; if (hold_bad != 0) begin bad++; $display("FAIL hold_stable got=%0d unstable cycles want=0", hold_bad); end
        total++; if (log_q.size() != log_n || busy !== 1'b1) begin
            bad++; $display("FAIL hold_start_ignored got accesses=%0d busy=%b want %0d/1", log_q.size(), busy, log_n);
        end
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_release got res_valid=%b busy=%b want 0", res_valid, busy); end
    endtask

    task automatic test_reset_mid();
        bit ok, got;
        int n = 0;
        logic [31:0] exp;
        start_frame(8'h07, 32'h04C1_1DB7);
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
        while (!(bus.data_write_n === 2'b00 && bus.address === 6'h08) && n < 200) begin @(negedge clk); n++; end
        total++; if (bus.data_write_n !== 2'b00) begin bad++; $display("FAIL rstmid_reach got write_n=%b want=00", bus.data_write_n); end
        rst = 1'b1;
        #1;
        total++; if (bus.data_write_n !== 2'b11 || bus.data_read_n !== 2'b11) begin
            bad++; $display("FAIL rstmid_bus got write_n=%b read_n=%b want 11/11", bus.data_write_n, bus.data_read_n);
        end
        total++; if (bus.address !== 6'h0 || bus.wdata !== 32'h0) begin bad++; $display("FAIL rstmid_addr got addr=%h wdata=%h want 0", bus.address, bus.wdata); end
        total++; if (busy !== 1'b0 || s_ready !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_ctrl got busy=%b s_ready=%b res_valid=%b want 0", busy, s_ready, res_valid);
        end
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        load_str("xyz");
        log_q.delete();
        exp_q.push_back(crc_ref(8'h07, 32'h04C1_1DB7));
        start_frame(8'h07, 32'h04C1_1DB7);
        send_frame(ok);
        wait_result(got);
        exp = exp_q.pop_front();
        total++; if (!got || res_crc !== exp) begin bad++; $display("FAIL rstmid_frame got=%h valid=%b want=%h", res_crc, got, exp); end
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0; @(negedge clk);
        total++; if (proto_bad != 0) begin bad++; $display("FAIL final_gap got=%0d violations want=0", proto_bad); end
    endtask

    initial begin
        test_reset();
        test_check_vector();
        test_timeout();
        test_abort();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
